// File: rtl/nibble_stim_gen.sv
// Stimulus generator and response checker for a nibble-wide device under test.
// A run issues num_vec stimulus vectors, each followed by a response window.
// Every vector is checked against a locally computed expected value, and the
// run ends with a one-cycle done pulse.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start; counters hold the last run's results
// SEND      | stim_valid high, data and select held until stim_ready
// WAIT_RESP | response window; ends on resp_valid or after TMO cycles
// DONE      | single-cycle done pulse, then back to IDLE

module nibble_stim_gen #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int TMO   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] stim_data,
    output logic             stim_sel,
    output logic             stim_valid,
    input  logic             stim_ready,
    input  logic [WIDTH-1:0] resp_data,
    input  logic             resp_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // The timeout counter counts down from TMO-1 to zero. The vector times
    // out on the cycle it sits at zero, so the response window is exactly
    // TMO cycles long.
    localparam int TMO_W = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_ZERO = '0;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [WIDTH-1:0] DATA_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] DATA_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    // Mode 3 has no pattern of its own; it is folded into increment when the
    // run is launched, so the datapath only ever sees three patterns.
    typedef enum logic [1:0] {
        PAT_INC   = 2'd0,
        PAT_LFSR  = 2'd1,
        PAT_CONST = 2'd2
    } pattern_t;

    state_t             state_q;
    state_t             state_d;

    pattern_t           pattern_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   expected_q;
    logic [CNT_W-1:0]   num_vec_q;
    logic [CNT_W-1:0]   vec_cnt_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;

    logic               launch;
    logic               xfer;
    logic               tmo_hit;
    logic               vec_done;
    logic               vec_err;
    logic               last_vec;
    logic [CNT_W-1:0]   vec_cnt_inc;

    // Result the device under test must return for a given stimulus. With
    // the select bit set, d + ~d is all ones for every d; the sum is kept
    // explicit so the intent stays readable.
    function automatic logic [WIDTH-1:0] expect_value(
        input logic [WIDTH-1:0] d,
        input logic             sel
    );
        logic [WIDTH-1:0] r;
        if (sel) begin
            r = d + ~d;
        end else begin
            r = (d << 1) + DATA_ONE;
        end
        return r;
    endfunction

    // Data value for the next vector. The LFSR is a Fibonacci register
    // shifting left, with feedback from the two top bits (x^4 + x^3 + 1 at
    // WIDTH = 4).
    function automatic logic [WIDTH-1:0] next_pattern(
        input pattern_t         pat,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] r;
        case (pat)
            PAT_LFSR:  r = {d[WIDTH-2:0], d[WIDTH-1] ^ d[WIDTH-2]};
            PAT_CONST: r = d;
            default:   r = d + DATA_ONE;
        endcase
        return r;
    endfunction

    // A seed of zero would lock the LFSR at zero, so it starts at one instead.
    function automatic logic [WIDTH-1:0] first_data(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] s
    );
        logic [WIDTH-1:0] r;
        if (m == 2'd1 && s == DATA_ZERO) begin
            r = DATA_ONE;
        end else begin
            r = s;
        end
        return r;
    endfunction

    // Events the FSM and the datapath both depend on.
    assign launch      = (state_q == S_IDLE) && start;
    assign xfer        = (state_q == S_SEND) && stim_ready;
    assign tmo_hit     = (state_q == S_WAIT_RESP) && !resp_valid && (tmo_cnt_q == TMO_ZERO);
    assign vec_done    = (state_q == S_WAIT_RESP) && (resp_valid || (tmo_cnt_q == TMO_ZERO));
    assign vec_err     = tmo_hit ||
                         ((state_q == S_WAIT_RESP) && resp_valid && (resp_data != expected_q));
    assign vec_cnt_inc = vec_cnt_q + CNT_ONE;
    assign last_vec    = (vec_cnt_inc == num_vec_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. An empty run goes straight from IDLE to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_vec == CNT_ZERO) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (stim_ready) begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (vec_done) begin
                    state_d = last_vec ? S_DONE : S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        stim_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_IDLE: busy       = 1'b0;
            S_SEND: stim_valid = 1'b1;
            S_DONE: done       = 1'b1;
            default: ;
        endcase
    end

    // Run configuration and the current data word. The data word only changes
    // at launch or when a vector completes, so it stays stable during SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= PAT_INC;
            num_vec_q <= CNT_ZERO;
            data_q    <= DATA_ZERO;
        end else if (launch) begin
            case (mode)
                2'd1:    pattern_q <= PAT_LFSR;
                2'd2:    pattern_q <= PAT_CONST;
                default: pattern_q <= PAT_INC;
            endcase
            num_vec_q <= num_vec;
            data_q    <= first_data(mode, seed);
        end else if (vec_done) begin
            data_q    <= next_pattern(pattern_q, data_q);
        end
    end

    // Expected response, captured on the stimulus handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            expected_q <= DATA_ZERO;
        end else if (xfer) begin
            expected_q <= expect_value(data_q, vec_cnt_q[0]);
        end
    end

    // Response timeout: loaded on the handshake, counts down while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= TMO_ZERO;
        end else if (xfer) begin
            tmo_cnt_q <= TMO_LOAD;
        end else if ((state_q == S_WAIT_RESP) && !resp_valid && (tmo_cnt_q != TMO_ZERO)) begin
            tmo_cnt_q <= tmo_cnt_q - TMO_ONE;
        end
    end

    // Vector counter: cleared at launch, stepped once per completed vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt_q <= CNT_ZERO;
        end else if (launch) begin
            vec_cnt_q <= CNT_ZERO;
        end else if (vec_done) begin
            vec_cnt_q <= vec_cnt_inc;
        end
    end

    // Error counter: mismatches and timeouts, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= CNT_ZERO;
        end else if (launch) begin
            err_cnt_q <= CNT_ZERO;
        end else if (vec_err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + CNT_ONE;
        end
    end

    assign stim_data = data_q;
    assign stim_sel  = vec_cnt_q[0];
    assign vec_cnt   = vec_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_nibble_stim_gen.sv
// Testbench for nibble_stim_gen: directed scenarios plus randomized runs.
// Expected values come from an arithmetic model of the pattern and expected-
// response rules, and the responder behaviour is planned per vector.
module tb_nibble_stim_gen;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int TMO   = 16;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic [1:0]       mode;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] stim_data;
    logic             stim_sel;
    logic             stim_valid;
    logic             stim_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-vector plan: ready delay, response kind
    // (0 correct, 1 wrong, 2 none, 3 zero) and response delay.
    int ready_dly [256];
    int resp_kind [256];
    int resp_dly  [256];

    always #5 clk = ~clk;

    nibble_stim_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TMO(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vec    (num_vec),
        .mode       (mode),
        .seed       (seed),
        .stim_data  (stim_data),
        .stim_sel   (stim_sel),
        .stim_valid (stim_valid),
        .stim_ready (stim_ready),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .busy       (busy),
        .done       (done),
        .vec_cnt    (vec_cnt),
        .err_cnt    (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int model_next(input int md, input int d);
        if (md == 1) return ((d << 1) | (((d >> 3) ^ (d >> 2)) & 1)) & MASK;
        if (md == 2) return d;
        return (d + 1) & MASK;
    endfunction

    function automatic int model_expect(input int sel, input int d);
        if (sel != 0) return (d + (MASK - d)) & MASK;
        return (2 * d + 1) & MASK;
    endfunction

    task automatic plan_clear();
        for (int i = 0; i < 256; i++) begin
            ready_dly[i] = 0;
            resp_kind[i] = 0;
            resp_dly[i]  = 0;
        end
    endtask

    task automatic plan_random(input int nv);
        for (int i = 0; i < nv; i++) begin
            int r;
            r = $urandom_range(11);
            ready_dly[i] = $urandom_range(3);
            resp_dly[i]  = $urandom_range(6);
            if (r < 7)       resp_kind[i] = 0;
            else if (r < 9)  resp_kind[i] = 1;
            else if (r < 10) resp_kind[i] = 2;
            else             resp_kind[i] = 3;
        end
    endtask

    // One complete run, starting and ending with the DUT in IDLE at a negedge.
    task automatic do_run(input int md, input int sd, input int nv);
        int d;
        int errs;
        int sel;
        int ex;
        d = sd;
        if (md == 1 && d == 0) d = 1;
        errs = 0;
        start   = 1'b1;
        mode    = 2'(md);
        seed    = 4'(sd);
        num_vec = 8'(nv);
        @(negedge clk);
        start   = 1'b0;
        mode    = 2'($urandom);
        seed    = 4'($urandom);
        num_vec = 8'($urandom);
        if (nv == 0) begin
            check("empty_done", done, 1);
            check("empty_busy", busy, 1);
            check("empty_valid", stim_valid, 0);
            check("empty_vec", vec_cnt, 0);
            check("empty_err", err_cnt, 0);
            @(negedge clk);
            check("empty_done_end", done, 0);
            check("empty_idle", busy, 0);
            check("empty_valid_end", stim_valid, 0);
            return;
        end
        for (int v = 0; v < nv; v++) begin
            sel = v & 1;
            check("send_valid", stim_valid, 1);
            check("send_data", stim_data, d);
            check("send_sel", stim_sel, sel);
            check("send_vec", vec_cnt, v);
            check("send_err", err_cnt, errs);
            for (int k = 0; k < ready_dly[v]; k++) begin
                resp_valid = 1'($urandom);
                resp_data  = 4'($urandom);
                start      = 1'($urandom);
                @(negedge clk);
                resp_valid = 1'b0;
                start      = 1'b0;
                check("hold_valid", stim_valid, 1);
                check("hold_data", stim_data, d);
                check("hold_sel", stim_sel, sel);
                check("hold_err", err_cnt, errs);
            end
            stim_ready = 1'b1;
            @(negedge clk);
            stim_ready = 1'b0;
            check("wait_valid", stim_valid, 0);
            ex = model_expect(sel, d);
            if (resp_kind[v] == 2) begin
                repeat (TMO - 1) @(negedge clk);
                check("tmo_pending_vec", vec_cnt, v);
                check("tmo_pending_busy", busy, 1);
                @(negedge clk);
                errs++;
            end else begin
                for (int k = 0; k < resp_dly[v]; k++) begin
                    start = 1'($urandom);
                    @(negedge clk);
                    start = 1'b0;
                end
                resp_valid = 1'b1;
                if (resp_kind[v] == 0) begin
                    resp_data = 4'(ex);
                end else if (resp_kind[v] == 1) begin
                    resp_data = 4'(ex ^ (1 + $urandom_range(14)));
                    errs++;
                end else begin
                    resp_data = 4'd0;
                    if (ex != 0) errs++;
                end
                @(negedge clk);
                resp_valid = 1'b0;
            end
            check("done_vec", vec_cnt, v + 1);
            check("done_err", err_cnt, errs);
            d = model_next(md, d);
            if (v == nv - 1) begin
                check("run_done", done, 1);
                check("run_done_valid", stim_valid, 0);
                @(negedge clk);
                check("run_done_end", done, 0);
                check("run_idle", busy, 0);
            end
        end
        repeat (3) @(negedge clk);
        check("hold_final_vec", vec_cnt, nv);
        check("hold_final_err", err_cnt, errs);
        check("hold_idle_valid", stim_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        num_vec    = '0;
        mode       = '0;
        seed       = '0;
        stim_ready = 1'b0;
        resp_data  = '0;
        resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", stim_valid, 0);
        check("rst_data", stim_data, 0);
        check("rst_sel", stim_sel, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_vec", vec_cnt, 0);
        check("rst_err", err_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Increment from 3: expected 7, 15, 11, 15 with a correct responder.
        plan_clear();
        do_run(0, 3, 4);

        // Increment wrapping 15 -> 0.
        plan_clear();
        do_run(0, 15, 2);

        // Ready withheld for five cycles on the first vector.
        plan_clear();
        ready_dly[0] = 5;
        do_run(2, 9, 2);

        // Zero response on vector 2, no response on vector 3.
        plan_clear();
        resp_kind[1] = 3;
        resp_kind[2] = 2;
        do_run(0, 5, 3);

        // Empty run.
        plan_clear();
        do_run(0, 7, 0);

        // LFSR with a zero seed, which must start from 1.
        plan_clear();
        do_run(1, 0, 6);

        // Reset in the middle of WAIT_RESP with start asserted alongside.
        start   = 1'b1;
        mode    = 2'd0;
        seed    = 4'd5;
        num_vec = 8'd3;
        @(negedge clk);
        start = 1'b0;
        stim_ready = 1'b1;
        @(negedge clk);
        stim_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 4'd0;
        @(negedge clk);
        resp_valid = 1'b0;
        check("pre_rst_vec", vec_cnt, 1);
        check("pre_rst_err", err_cnt, 1);
        stim_ready = 1'b1;
        @(negedge clk);
        stim_ready = 1'b0;
        check("pre_rst_wait", stim_valid, 0);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", stim_valid, 0);
        check("mid_rst_data", stim_data, 0);
        check("mid_rst_sel", stim_sel, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_vec", vec_cnt, 0);
        check("mid_rst_err", err_cnt, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        check("post_rst_valid", stim_valid, 0);

        // Randomized runs across all modes, including mode 3.
        for (int r = 0; r < 14; r++) begin
            int md;
            int sd;
            int nv;
            md = $urandom_range(3);
            sd = $urandom_range(15);
            nv = $urandom_range(1, 8);
            plan_random(nv);
            do_run(md, sd, nv);
        end

        // Longer LFSR run covering the full sequence period.
        plan_random(20);
        do_run(1, 11, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nibble_stim_gen.md
NIBBLE_STIM_GEN -- requirements
Module: nibble_stim_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4, stimulus/response data width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, width of the vector count, vector counter and error counter.
REQ-003 SHALL have parameter TMO, default 16, response timeout in cycles.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  launches a run when sampled high in IDLE.
REQ-007 SHALL have port num_vec  input  CNT_W  number of vectors per run, sampled on accepted start.
REQ-008 SHALL have port mode  input  2  data pattern (0 increment, 1 LFSR, 2 constant, 3 treated as 0), sampled on accepted start.
REQ-009 SHALL have port seed  input  WIDTH  first data value, sampled on accepted start.
REQ-010 SHALL have port stim_data  output  WIDTH  stimulus nibble.
REQ-011 SHALL have port stim_sel  output  1  stimulus select bit (x).
REQ-012 SHALL have port stim_valid  output  1  stimulus valid.
REQ-013 SHALL have port stim_ready  input  1  downstream accepts stimulus.
REQ-014 SHALL have port resp_data  input  WIDTH  returned result.
REQ-015 SHALL have port resp_valid  input  1  resp_data valid.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-018 SHALL have port vec_cnt  output  CNT_W  vectors completed in the current or last run.
REQ-019 SHALL have port err_cnt  output  CNT_W  mismatches plus timeouts in the current or last run.

Function
REQ-020 SHALL implement FSM states IDLE, SEND, WAIT_RESP, DONE.
REQ-021 IDLE with start=1: SHALL clear vec_cnt and err_cnt, load data register from seed (LFSR mode: seed 0 replaced by 1), go to SEND; num_vec=0 goes directly to DONE.
REQ-022 start while busy SHALL be ignored.
REQ-023 SEND: stim_valid SHALL be 1; stim_data/stim_sel SHALL hold stable until the cycle stim_valid&stim_ready=1.
REQ-024 stim_sel SHALL equal bit 0 of vec_cnt (alternates 0,1,0,... starting at 0).
REQ-025 On transfer SHALL latch expected = (stim_sel ? stim_data + ~stim_data : 2*stim_data + 1) mod 2^WIDTH, clear timeout counter, go to WAIT_RESP next cycle.
REQ-026 WAIT_RESP: stim_valid SHALL be 0; on resp_valid=1 compare resp_data with expected, increment err_cnt on mismatch.
REQ-027 WAIT_RESP with no resp_valid for TMO cycles SHALL count one error and complete the vector.
REQ-028 Vector completion SHALL increment vec_cnt and advance data: mode 0 +1 wrapping 2^WIDTH-1 -> 0; mode 1 Fibonacci LFSR x^4+x^3+1 (WIDTH=4); mode 2 unchanged.
REQ-029 After completion, vec_cnt==num_vec SHALL go to DONE, else SEND (next stim_valid the cycle after completion).
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-031 resp_valid outside WAIT_RESP SHALL be ignored (no count change).
REQ-032 err_cnt SHALL saturate at 2^CNT_W-1.
REQ-033 vec_cnt/err_cnt SHALL hold their final values in IDLE until next accepted start.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE, stim_valid=0, stim_data=0, stim_sel=0, done=0, busy=0, vec_cnt=0, err_cnt=0, regardless of state, including mid-handshake; start in the same cycle as rst SHALL be ignored.

Verification
REQ-035 mode=0, seed=3, num_vec=4, ready tied 1, correct responder -> stim (3,0),(4,1),(5,0),(6,1), expected 7,15,11,15; done pulse; vec_cnt=4, err_cnt=0.
REQ-036 mode=0, seed=15, num_vec=2 -> stim (15,0) then (0,1); expected 15 then 15; err_cnt=0.
REQ-037 stim_ready held 0 for 5 cycles -> stim_data/stim_sel stable, stim_valid=1 all 5 cycles, single transfer counted.
REQ-038 responder returns resp_data=0 for vector 2 of 3, never responds for vector 3 -> timeout after 16 cycles; err_cnt=2, vec_cnt=3, done pulses.
REQ-039 num_vec=0 with start -> DONE next cycle, done=1 one cycle, no stim_valid, counters 0.
REQ-040 rst asserted during WAIT_RESP -> next cycle IDLE, all outputs reset values; start pulse while busy produces no restart.
